// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. A small controller pops one byte per
// transmitter busy/idle cycle and presents it with a one-cycle launch pulse.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    input  logic                  is_transmitting
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [7:0]              mem_q [DEPTH];
    logic [7:0]              mem_d [DEPTH];
    logic                    launch_vld_p0_q, launch_vld_p0_d;
    logic [7:0]              launch_byte_p0_q, launch_byte_p0_d;
    logic                    transmit_q, transmit_d;
    logic [7:0]              tx_byte_q, tx_byte_d;

    logic                    is_full;
    logic                    pop;
    logic                    wr_accept;

    // Storage, pointers and occupancy; a pop frees a slot for a same-cycle write.
    always_comb begin
        is_full   = (count_q == CW'(DEPTH));
        pop       = (state_q == IDLE) && (count_q != '0) && !is_transmitting;
        wr_accept = wr_en && (!is_full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        count_d    = count_q + CW'(wr_accept) - CW'(pop);
        overflow_d = overflow_q | (wr_en & ~wr_accept);
    end

    // Stage p0: popped byte staged one cycle before it is presented.
    always_comb begin
        launch_vld_p0_d  = pop;
        launch_byte_p0_d = pop ? mem_q[rd_ptr_q] : launch_byte_p0_q;
    end

    // Output stage: pulse and byte change together; byte holds between launches.
    always_comb begin
        transmit_d = launch_vld_p0_q;
        tx_byte_d  = launch_vld_p0_q ? launch_byte_p0_q : tx_byte_q;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pop) begin
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                // Give up on a transmitter that never reports busy; the byte is lost.
                if (is_transmitting) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!is_transmitting) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
            launch_vld_p0_q <= 1'b0;
            transmit_q      <= 1'b0;
            tx_byte_q       <= 8'h00;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
            launch_vld_p0_q <= launch_vld_p0_d;
            transmit_q      <= transmit_d;
            tx_byte_q       <= tx_byte_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q            <= mem_d;
        launch_byte_p0_q <= launch_byte_p0_d;
    end

    assign full     = is_full;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, which sets the FIFO depth to 2^DEPTH_LOG2 bytes (16 by default).
REQ-002 SHALL have parameter TIMEOUT, default 4, the maximum number of cycles to wait for the transmitter to report busy after a launch.
REQ-003 SHALL have port clk, input, 1 bit: the master clock; it is the only clock in the block.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: write strobe; one byte is offered per cycle in which it is high.
REQ-006 SHALL have port wr_data, input, 8 bits: the byte to enqueue, sampled when wr_en is high.
REQ-007 SHALL have port full, output, 1 bit: high when count equals 2^DEPTH_LOG2.
REQ-008 SHALL have port count, output, DEPTH_LOG2+1 bits: number of bytes stored.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag set when a write is dropped.
REQ-010 SHALL have port transmit, output, 1 bit: one-cycle launch pulse to the UART transmitter.
REQ-011 SHALL have port tx_byte, output, 8 bits: the byte presented to the UART transmitter.
REQ-012 SHALL have port is_transmitting, input, 1 bit: busy indication from the UART transmitter.

Function
REQ-013 SHALL implement a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo 2^DEPTH_LOG2.
REQ-014 SHALL accept a write when wr_en=1 and either count is below the depth or a pop occurs in the same cycle.
REQ-015 SHALL, when wr_en=1 while full and no pop occurs, drop the byte, leave the pointers and count unchanged, and set overflow=1.
REQ-016 SHALL apply count changes as follows: write only +1, pop only -1, write and pop together leaves count unchanged.
REQ-017 SHALL use a controller FSM with the states IDLE, WAIT_START and WAIT_DONE.
REQ-018 SHALL, in IDLE with count!=0 and is_transmitting=0, pop the head byte, register it to tx_byte, assert transmit for exactly one cycle, and move to WAIT_START.
REQ-019 SHALL, in WAIT_START, move to WAIT_DONE when is_transmitting=1.
REQ-020 SHALL, in WAIT_START, return to IDLE after TIMEOUT cycles without is_transmitting=1; the popped byte is not re-queued.
REQ-021 SHALL, in WAIT_DONE, move to IDLE on the first cycle with is_transmitting=0.
REQ-022 SHALL, in IDLE with count=0, or with is_transmitting=1, hold the state and keep transmit=0.
REQ-023 SHALL assert transmit and present the new tx_byte value in the same cycle.
REQ-024 SHALL hold tx_byte at its last value until the next launch.
REQ-025 SHALL have a first-byte latency into an empty, idle FIFO of exactly 2 edges: wr_en sampled at edge E0 produces transmit=1 in the cycle after edge E2.
REQ-026 SHALL launch at most one byte per transmitter busy/idle cycle and never assert transmit on two consecutive cycles.
REQ-027 SHALL preserve byte order: bytes leave in the exact order in which they were accepted.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, force pointers=0, count=0, full=0, overflow=0, transmit=0, tx_byte=8'h00 and FSM=IDLE.
REQ-029 SHALL give rst priority over wr_en and launch in the same cycle; stored bytes are discarded.
REQ-030 SHALL, when reset mid-transmission, not abort the UART; after reset the FSM waits in IDLE until is_transmitting=0 before the next launch.

Verification
REQ-031 SHALL be covered by a single-byte test: write 8'hA5 into an idle FIFO with is_transmitting=0 -> transmit pulses on the 2nd edge after the write, tx_byte=8'hA5, and count returns to 0.
REQ-032 SHALL be covered by a burst-order test: write 8'h01..8'h05 on back-to-back cycles with the UART model busy for 20 cycles per byte -> exactly 5 transmit pulses carrying 01,02,03,04,05 in order, each launched only after is_transmitting falls.
REQ-033 SHALL be covered by a full/overflow test: hold is_transmitting=1 and write 17 bytes -> full=1 and count=16 after the 16th write, the 17th byte is dropped, overflow=1, and overflow stays high after the FIFO drains.
REQ-034 SHALL be covered by a write-while-full-with-pop test: FIFO full, drop is_transmitting to 0 while writing 8'h77 in the launch cycle -> the write is accepted, count stays 16, and 8'h77 emerges last.
REQ-035 SHALL be covered by a timeout test: the UART model never asserts is_transmitting -> the FSM returns to IDLE after 4 cycles in WAIT_START and launches the next byte.
REQ-036 SHALL be covered by a reset-mid-burst test: 3 bytes queued and rst pulsed during WAIT_DONE -> count=0, overflow=0, tx_byte=8'h00, and no transmit pulse until a new write.
